// File: rtl/mmss_up_counter.sv
// ============================================================================
// Module   : mmss_up_counter
// Brief    : MM:SS BCD up-counter with IDLE/RUN/PAUSED control, preset load,
//            rollover pulse and optional lap freeze (macro MMSS_LAP_EN).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mmss_up_counter #(
    parameter int MIN_TENS_MAX = 5
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        tick,
    input  logic        start,
    input  logic        stop,
    input  logic        clear,
    input  logic        load,
    input  logic [15:0] datain,
    input  logic        lap,
    output logic [3:0]  sec_ones,
    output logic [3:0]  sec_tens,
    output logic [3:0]  min_ones,
    output logic [3:0]  min_tens,
    output logic        running,
    output logic        wrap,
    output logic        zero
);

    localparam logic [3:0] c_SO_MAX = 4'd9;
    localparam logic [3:0] c_ST_MAX = 4'd5;
    localparam logic [3:0] c_MO_MAX = 4'd9;
    localparam logic [3:0] c_MT_MAX = 4'(MIN_TENS_MAX);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_RUN    = 2'd1,
        S_PAUSED = 2'd2
    } state_t;

    state_t     r_state;
    state_t     w_state_nxt;

    logic [3:0] r_so;
    logic [3:0] r_st;
    logic [3:0] r_mo;
    logic [3:0] r_mt;
    logic       r_wrap;

    logic       w_adv;
    logic       w_so_max;
    logic       w_st_max;
    logic       w_mo_max;
    logic       w_mt_max;
    logic       w_at_max;
    logic [15:0] w_live;
    logic [15:0] w_disp;

    function automatic logic [3:0] f_clamp(input logic [3:0] d, input logic [3:0] mx);
        return (d > mx) ? mx : d;
    endfunction

    // ------------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Priority clear > load > stop > start; stop swallows a coincident start.
    always_comb begin
        w_state_nxt = r_state;
        if (clear) begin
            w_state_nxt = S_IDLE;
        end else if (load) begin
            w_state_nxt = r_state;
        end else if (stop) begin
            if (r_state == S_RUN) begin
                w_state_nxt = S_PAUSED;
            end
        end else if (start) begin
            if (r_state != S_RUN) begin
                w_state_nxt = S_RUN;
            end
        end
    end

    // A tick only counts when nothing of higher priority is present.
    assign w_adv    = (r_state == S_RUN) && tick && !clear && !load && !stop && !start;

    assign w_so_max = (r_so == c_SO_MAX);
    assign w_st_max = (r_st == c_ST_MAX);
    assign w_mo_max = (r_mo == c_MO_MAX);
    assign w_mt_max = (r_mt == c_MT_MAX);
    assign w_at_max = w_so_max && w_st_max && w_mo_max && w_mt_max;

    // ------------------------------------------------------------------------
    // BCD digit chain and rollover pulse
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_so   <= 4'd0;
            r_st   <= 4'd0;
            r_mo   <= 4'd0;
            r_mt   <= 4'd0;
            r_wrap <= 1'b0;
        end else begin
            r_wrap <= 1'b0;
            if (clear) begin
                r_so <= 4'd0;
                r_st <= 4'd0;
                r_mo <= 4'd0;
                r_mt <= 4'd0;
            end else if (load) begin
                r_mt <= f_clamp(datain[15:12], c_MT_MAX);
                r_mo <= f_clamp(datain[11:8],  c_MO_MAX);
                r_st <= f_clamp(datain[7:4],   c_ST_MAX);
                r_so <= f_clamp(datain[3:0],   c_SO_MAX);
            end else if (w_adv) begin
                r_wrap <= w_at_max;
                r_so   <= w_so_max ? 4'd0 : r_so + 4'd1;
                if (w_so_max) begin
                    r_st <= w_st_max ? 4'd0 : r_st + 4'd1;
                    if (w_st_max) begin
                        r_mo <= w_mo_max ? 4'd0 : r_mo + 4'd1;
                        if (w_mo_max) begin
                            r_mt <= w_mt_max ? 4'd0 : r_mt + 4'd1;
                        end
                    end
                end
            end
        end
    end

    assign w_live = {r_mt, r_mo, r_st, r_so};

    // ------------------------------------------------------------------------
    // Optional lap freeze of the displayed value
    // ------------------------------------------------------------------------
`ifdef MMSS_LAP_EN
    logic        r_frozen;
    logic [15:0] r_cap;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_frozen <= 1'b0;
            r_cap    <= 16'd0;
        end else if (clear || load) begin
            r_frozen <= 1'b0;
        end else if (lap && (r_state == S_RUN)) begin
            r_frozen <= ~r_frozen;
            if (!r_frozen) begin
                r_cap <= w_live;
            end
        end
    end

    assign w_disp = r_frozen ? r_cap : w_live;
`else
    logic w_unused_lap;
    assign w_unused_lap = lap;
    assign w_disp       = w_live;
`endif

    assign min_tens = w_disp[15:12];
    assign min_ones = w_disp[11:8];
    assign sec_tens = w_disp[7:4];
    assign sec_ones = w_disp[3:0];
    assign running  = (r_state == S_RUN);
    assign wrap     = r_wrap;
    assign zero     = (w_live == 16'd0);

endmodule

`default_nettype wire

// File: tb/tb_mmss_up_counter.sv
// ============================================================================
// Module   : tb_mmss_up_counter
// Brief    : Directed, table-driven self-checking bench for mmss_up_counter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mmss_up_counter;

    localparam logic [5:0] c_T = 6'b100000;  // tick
    localparam logic [5:0] c_S = 6'b010000;  // start
    localparam logic [5:0] c_P = 6'b001000;  // stop
    localparam logic [5:0] c_C = 6'b000100;  // clear
    localparam logic [5:0] c_L = 6'b000010;  // load
    localparam logic [5:0] c_A = 6'b000001;  // lap
    localparam int         c_NV = 30;

    typedef struct {
        logic [5:0]  ctl;
        logic [15:0] din;
        logic [15:0] exp_d;
        logic        exp_run;
        logic        exp_wrap;
        logic        exp_zero;
    } vec_t;

    logic        clk;
    logic        reset;
    logic        tick, start, stop, clear, load, lap;
    logic [15:0] datain;
    logic [3:0]  sec_ones, sec_tens, min_ones, min_tens;
    logic        running, wrap, zero;

    int checks;
    int errors;
    vec_t vec [c_NV];

    mmss_up_counter #(.MIN_TENS_MAX(5)) dut (
        .clk(clk), .reset(reset), .tick(tick), .start(start), .stop(stop),
        .clear(clear), .load(load), .datain(datain), .lap(lap),
        .sec_ones(sec_ones), .sec_tens(sec_tens), .min_ones(min_ones),
        .min_tens(min_tens), .running(running), .wrap(wrap), .zero(zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    task automatic chk_all(input string nm, input logic [15:0] d, input logic r,
                           input logic w, input logic z);
        chk({nm, ".digits"},  {min_tens, min_ones, sec_tens, sec_ones}, d);
        chk({nm, ".running"}, {15'd0, running}, {15'd0, r});
        chk({nm, ".wrap"},    {15'd0, wrap},    {15'd0, w});
        chk({nm, ".zero"},    {15'd0, zero},    {15'd0, z});
    endtask

    // Drives one cycle of inputs, lets an edge pass, returns at edge + 1.
    task automatic step(input logic [5:0] ctl, input logic [15:0] d);
        {tick, start, stop, clear, load, lap} = ctl;
        datain = d;
        @(posedge clk);
        #1;
        {tick, start, stop, clear, load, lap} = 6'b0;
        datain = 16'h0000;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset  = 1'b1;
        {tick, start, stop, clear, load, lap} = 6'b0;
        datain = 16'h0000;

        vec[0]  = '{c_C,         16'h0000, 16'h0000, 1'b0, 1'b0, 1'b1};
        vec[1]  = '{c_L,         16'h5959, 16'h5959, 1'b0, 1'b0, 1'b0};
        vec[2]  = '{c_S,         16'h0000, 16'h5959, 1'b1, 1'b0, 1'b0};
        vec[3]  = '{c_T,         16'h0000, 16'h0000, 1'b1, 1'b1, 1'b1};
        vec[4]  = '{6'b0,        16'h0000, 16'h0000, 1'b1, 1'b0, 1'b1};
        vec[5]  = '{c_L,         16'h9979, 16'h5959, 1'b1, 1'b0, 1'b0};
        vec[6]  = '{c_C,         16'h0000, 16'h0000, 1'b0, 1'b0, 1'b1};
        vec[7]  = '{c_T,         16'h0000, 16'h0000, 1'b0, 1'b0, 1'b1};
        vec[8]  = '{c_S|c_T,     16'h0000, 16'h0000, 1'b1, 1'b0, 1'b1};
        vec[9]  = '{c_T,         16'h0000, 16'h0001, 1'b1, 1'b0, 1'b0};
        vec[10] = '{c_T,         16'h0000, 16'h0002, 1'b1, 1'b0, 1'b0};
        vec[11] = '{c_S|c_P|c_T, 16'h0000, 16'h0002, 1'b0, 1'b0, 1'b0};
        vec[12] = '{c_T,         16'h0000, 16'h0002, 1'b0, 1'b0, 1'b0};
        vec[13] = '{c_S,         16'h0000, 16'h0002, 1'b1, 1'b0, 1'b0};
        vec[14] = '{c_T,         16'h0000, 16'h0003, 1'b1, 1'b0, 1'b0};
        vec[15] = '{c_P,         16'h0000, 16'h0003, 1'b0, 1'b0, 1'b0};
        vec[16] = '{c_L,         16'h1234, 16'h1234, 1'b0, 1'b0, 1'b0};
        vec[17] = '{c_S,         16'h0000, 16'h1234, 1'b1, 1'b0, 1'b0};
        vec[18] = '{c_T,         16'h0000, 16'h1235, 1'b1, 1'b0, 1'b0};
        vec[19] = '{c_L,         16'h0959, 16'h0959, 1'b1, 1'b0, 1'b0};
        vec[20] = '{c_T,         16'h0000, 16'h1000, 1'b1, 1'b0, 1'b0};
        vec[21] = '{c_L,         16'h0709, 16'h0709, 1'b1, 1'b0, 1'b0};
        vec[22] = '{c_T,         16'h0000, 16'h0710, 1'b1, 1'b0, 1'b0};
        vec[23] = '{c_L|c_T,     16'h0000, 16'h0000, 1'b1, 1'b0, 1'b1};
        vec[24] = '{c_P|c_T,     16'h0000, 16'h0000, 1'b0, 1'b0, 1'b1};
        vec[25] = '{c_S,         16'h0000, 16'h0000, 1'b1, 1'b0, 1'b1};
        vec[26] = '{c_C|c_S|c_T, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b1};
        vec[27] = '{c_S|c_P,     16'h0000, 16'h0000, 1'b0, 1'b0, 1'b1};
        vec[28] = '{c_L,         16'h6AFF, 16'h5959, 1'b0, 1'b0, 1'b0};
        vec[29] = '{c_C,         16'h0000, 16'h0000, 1'b0, 1'b0, 1'b1};

        // Reset state, observed with no clock edge involvement required
        #12;
        chk_all("reset", 16'h0000, 1'b0, 1'b0, 1'b1);
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Start then 75 ticks -> 01:15
        step(c_S, 16'h0000);
        for (int i = 0; i < 75; i++) step(c_T, 16'h0000);
        chk_all("ticks75", 16'h0115, 1'b1, 1'b0, 1'b0);

        step(c_C, 16'h0000);
        for (int i = 0; i < c_NV; i++) begin
            step(vec[i].ctl, vec[i].din);
            chk_all($sformatf("vec%0d", i), vec[i].exp_d, vec[i].exp_run,
                    vec[i].exp_wrap, vec[i].exp_zero);
        end

        // Reset between edges at 03:27 in RUN
        step(c_L, 16'h0327);
        step(c_S, 16'h0000);
        chk_all("pre_reset", 16'h0327, 1'b1, 1'b0, 1'b0);
        #3 reset = 1'b1;
        #1;
        chk_all("mid_reset", 16'h0000, 1'b0, 1'b0, 1'b1);
        #3 reset = 1'b0;
        @(posedge clk);
        #1;
        step(c_T, 16'h0000);
        chk_all("post_reset_tick", 16'h0000, 1'b0, 1'b0, 1'b1);
        step(c_S, 16'h0000);
        step(c_T, 16'h0000);
        chk_all("post_reset_run", 16'h0001, 1'b1, 1'b0, 1'b0);

        // Lap freeze sequence
        step(c_C, 16'h0000);
        step(c_L, 16'h0010);
        step(c_S, 16'h0000);
        step(c_A, 16'h0000);
        for (int i = 0; i < 5; i++) step(c_T, 16'h0000);
`ifdef MMSS_LAP_EN
        chk_all("lap_hold", 16'h0010, 1'b1, 1'b0, 1'b0);
`else
        chk_all("lap_hold", 16'h0015, 1'b1, 1'b0, 1'b0);
`endif
        step(c_A, 16'h0000);
        chk_all("lap_release", 16'h0015, 1'b1, 1'b0, 1'b0);
        step(c_P, 16'h0000);
        step(c_A, 16'h0000);
        chk_all("lap_paused", 16'h0015, 1'b0, 1'b0, 1'b0);
        step(c_S, 16'h0000);
        step(c_T, 16'h0000);
        chk_all("lap_ignored", 16'h0016, 1'b1, 1'b0, 1'b0);
        step(c_A, 16'h0000);
        step(c_T, 16'h0000);
`ifdef MMSS_LAP_EN
        chk_all("lap_frozen2", 16'h0016, 1'b1, 1'b0, 1'b0);
`else
        chk_all("lap_frozen2", 16'h0017, 1'b1, 1'b0, 1'b0);
`endif
        step(c_L, 16'h0100);
        chk_all("lap_load_ends", 16'h0100, 1'b1, 1'b0, 1'b0);
        step(c_T, 16'h0000);
        chk_all("lap_after_load", 16'h0101, 1'b1, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/mmss_up_counter.md
MMSS_UP_COUNTER -- requirements
Module: mmss_up_counter

Interface
REQ-001 Parameter MIN_TENS_MAX, default 5: maximum value of the minutes-tens digit, legal range 1..9.
REQ-002 clk  in  1  system clock; all state updates occur on its rising edge.
REQ-003 reset  in  1  asynchronous, active-high reset.
REQ-004 tick  in  1  one-clk-wide count strobe (1 Hz in system use).
REQ-005 start  in  1  one-clk pulse; begin or resume counting.
REQ-006 stop  in  1  one-clk pulse; pause counting.
REQ-007 clear  in  1  one-clk pulse; zero all digits and go idle.
REQ-008 load  in  1  one-clk pulse; preset digits from datain.
REQ-009 datain  in  16  preset value {min_tens, min_ones, sec_tens, sec_ones}, 4 bits BCD each.
REQ-010 lap  in  1  one-clk pulse; toggle display freeze (only with LAP_EN).
REQ-011 sec_ones, sec_tens, min_ones, min_tens  out  4 each  displayed BCD digits.
REQ-012 running  out  1  high while the FSM is in RUN.
REQ-013 wrap  out  1  one-clk pulse on rollover from max to 00:00.
REQ-014 zero  out  1  combinational; high when all four live digits are 0.

Function
REQ-015 FSM states SHALL be IDLE, RUN and PAUSED.
REQ-016 Transitions SHALL be: IDLE/PAUSED + start -> RUN; RUN + stop -> PAUSED; any state + clear -> IDLE; load leaves the state unchanged.
REQ-017 Per-cycle priority SHALL be clear > load > stop > start > tick; with start and stop together, stop wins.
REQ-018 The count SHALL advance only on a cycle where state = RUN, tick = 1, and clear, load and stop are all 0; a tick arriving in the same cycle as start is not counted.
REQ-019 Digit ranges SHALL be: sec_ones 0..9; sec_tens 0..5; min_ones 0..9; min_tens 0..MIN_TENS_MAX.
REQ-020 Carry chain: each digit at its maximum rolls to 0 and increments the next digit, all in the same clock edge.
REQ-021 At MIN_TENS_MAX9:59 an advance SHALL produce 00:00, assert wrap for exactly the next cycle, and keep state RUN.
REQ-022 Load SHALL clamp each digit to its own maximum (e.g. sec_tens 7 -> 5; min_tens 9 -> MIN_TENS_MAX).
REQ-023 Latency: digit outputs, running and wrap SHALL update one clk after the causing input; zero follows the live digits combinationally.
REQ-024 clear or load SHALL also terminate any active lap freeze.

Reset
REQ-025 While reset is high, all digits SHALL be 0, state SHALL be IDLE, running and wrap SHALL be 0, and lap freeze SHALL be off, independent of clk.
REQ-026 Reset asserted mid-count SHALL discard the count; after release, counting resumes only after a new start.

Configuration
REQ-027 Macro MMSS_LAP_EN: when defined, a lap pulse in RUN toggles freeze. While frozen, the outputs show the digits captured at the lap edge and the internal count keeps advancing; a second lap pulse returns the outputs to the live digits. A lap pulse outside RUN is ignored.
REQ-028 Without MMSS_LAP_EN: no freeze register exists, lap is ignored, and the outputs always show the live digits.

Verification
REQ-029 Reset, start, then 75 ticks -> outputs 01:15, running = 1, zero = 0.
REQ-030 Load datain = 0x5959, start, 1 tick -> 00:00, one-cycle wrap pulse, running stays 1.
REQ-031 Load datain = 0x9979 -> clamped to 59:59; clear -> 00:00, zero = 1, state IDLE.
REQ-032 In RUN, start and stop together, with tick in the same cycle -> PAUSED and count unchanged; later ticks are ignored until the next start.
REQ-033 MMSS_LAP_EN, at 00:10: lap, then 5 ticks -> outputs hold 00:10; lap again -> outputs 00:15.
REQ-034 Reset asserted between clk edges while at 03:27 in RUN -> outputs 00:00 immediately, running = 0.
